// File: rtl/start_stagger_ctrl.sv
// Staggered start generator for NoC endpoints: releases per-node start bits in
// groups of GROUP nodes, GAP cycles apart, in LINEAR, REVERSE or INTERLEAVE order.
module start_stagger_ctrl #(
    parameter int    NC       = 64,
    parameter int    GAP      = 8,
    parameter int    GROUP    = 1,
    parameter string ORDER    = "LINEAR",
    parameter string OUT_MODE = "PULSE",
    localparam int   S        = (NC + GROUP - 1) / GROUP,
    localparam int   STEP_W   = $clog2(S) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              clear_i,
    output logic [NC-1:0]     start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [STEP_W-1:0] step_o
);

    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(S - 1);

    localparam bit ORDER_OK = (ORDER == "LINEAR") || (ORDER == "REVERSE") ||
                              (ORDER == "INTERLEAVE");
    localparam bit MODE_OK  = (OUT_MODE == "PULSE") || (OUT_MODE == "LEVEL");
    localparam bit RANGE_OK = (NC >= 2) && (NC <= 1024) && (GAP >= 1) && (GAP <= 255) &&
                              (GROUP >= 1) && (GROUP <= NC);

    generate
        if (!(ORDER_OK && MODE_OK && RANGE_OK)) begin : g_bad_config
            $fatal(1, "start_stagger_ctrl: illegal NC/GAP/GROUP/ORDER/OUT_MODE");
        end
    endgenerate

    // Order position -> physical node index.
    function automatic int node_of(input int p);
        int h;
        h = (NC + 1) / 2;
        if (ORDER == "REVERSE")
            return NC - 1 - p;
        else if (ORDER == "INTERLEAVE")
            return (p < h) ? 2 * p : 2 * (p - h) + 1;
        else
            return p;
    endfunction

    function automatic logic [NC-1:0] build_mask(input int s);
        logic [NC-1:0] m;
        m = '0;
        for (int p = 0; p < NC; p++) begin
            if ((p >= s * GROUP) && (p < (s + 1) * GROUP))
                m[node_of(p)] = 1'b1;
        end
        return m;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              start_prev_q;
    logic              trigger;
    logic [NC-1:0]     mask_tbl [S];
    logic [NC-1:0]     cur_mask;
    logic [NC-1:0]     fire_mask;

    // Step masks are fixed at elaboration; the run-time path is only a mux.
    generate
        for (genvar g = 0; g < S; g++) begin : g_mask
            assign mask_tbl[g] = build_mask(g);
        end
    endgenerate

    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < S; i++) begin
            if (step_q == STEP_W'(i))
                cur_mask = mask_tbl[i];
        end
    end

    assign trigger   = start_i && !start_prev_q && (state_q == S_IDLE) && !clear_i;
    assign fire_mask = (state_q == S_FIRE) ? cur_mask : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            gap_q        <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            start_prev_q <= start_i;
        end
    end

    // clear_i wins over everything, including a simultaneous trigger.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        gap_d   = gap_q;
        if (clear_i) begin
            state_d = S_IDLE;
            step_d  = '0;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_d = S_FIRE;
                        step_d  = '0;
                    end
                end
                S_FIRE: begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end else if (GAP == 1) begin
                        step_d  = step_q + STEP_W'(1);
                    end else begin
                        state_d = S_WAIT;
                        gap_d   = GAP_W'(GAP - 1);
                    end
                end
                S_WAIT: begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        state_d = S_FIRE;
                        step_d  = step_q + STEP_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    generate
        if (OUT_MODE == "LEVEL") begin : g_level
            logic [NC-1:0] level_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    level_q <= '0;
                else if (clear_i)
                    level_q <= '0;
                else
                    level_q <= level_q | fire_mask;
            end

            assign start_o = level_q | fire_mask;
        end else begin : g_pulse
            assign start_o = fire_mask;
        end
    endgenerate

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FIRE) && (step_q == LAST_STEP);
    assign step_o = step_q;

endmodule

// File: tb/tb_start_stagger_ctrl.sv
// Directed bench for start_stagger_ctrl: three configurations exercised against
// hand-computed release schedules, clear, held start and asynchronous reset.
module tb_start_stagger_ctrl;

    logic clk;
    logic reset;

    logic       a_start, a_clear, a_busy, a_done;
    logic [7:0] a_out;
    logic [3:0] a_step;

    logic       b_start, b_clear, b_busy, b_done;
    logic [9:0] b_out;
    logic [2:0] b_step;

    logic       c_start, c_clear, c_busy, c_done;
    logic [4:0] c_out;
    logic [2:0] c_step;

    int checks;
    int errors;

    start_stagger_ctrl #(
        .NC(8), .GAP(4), .GROUP(1), .ORDER("LINEAR"), .OUT_MODE("PULSE")
    ) dut_a (
        .clk(clk), .reset(reset), .start_i(a_start), .clear_i(a_clear),
        .start_o(a_out), .busy_o(a_busy), .done_o(a_done), .step_o(a_step)
    );

    start_stagger_ctrl #(
        .NC(10), .GAP(3), .GROUP(4), .ORDER("INTERLEAVE"), .OUT_MODE("LEVEL")
    ) dut_b (
        .clk(clk), .reset(reset), .start_i(b_start), .clear_i(b_clear),
        .start_o(b_out), .busy_o(b_busy), .done_o(b_done), .step_o(b_step)
    );

    start_stagger_ctrl #(
        .NC(5), .GAP(1), .GROUP(2), .ORDER("REVERSE"), .OUT_MODE("PULSE")
    ) dut_c (
        .clk(clk), .reset(reset), .start_i(c_start), .clear_i(c_clear),
        .start_o(c_out), .busy_o(c_busy), .done_o(c_done), .step_o(c_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one edge's inputs {c,b,a}, then return at the following negedge to sample.
    task automatic applyStimulus(input logic [2:0] st, input logic [2:0] cl);
        a_start = st[0]; b_start = st[1]; c_start = st[2];
        a_clear = cl[0]; b_clear = cl[1]; c_clear = cl[2];
        @(posedge clk);
        @(negedge clk);
    endtask

    // Config A schedule, rel = cycles since the trigger edge (1 = first pulse).
    function automatic int a_pulse(input int rel);
        if (rel >= 1 && rel <= 29 && ((rel - 1) % 4) == 0) return 1 << ((rel - 1) / 4);
        return 0;
    endfunction

    function automatic int a_stepv(input int rel);
        return (rel >= 1 && rel <= 29) ? (rel - 1) / 4 : 0;
    endfunction

    task automatic checkA(input string sc, input int cyc, input int rel);
        checkOutput($sformatf("%s start c%0d", sc, cyc), 32'(a_out), 32'(a_pulse(rel)));
        checkOutput($sformatf("%s busy c%0d", sc, cyc), 32'(a_busy), 32'(rel >= 1 && rel <= 29));
        checkOutput($sformatf("%s done c%0d", sc, cyc), 32'(a_done), 32'(rel == 29));
        checkOutput($sformatf("%s step c%0d", sc, cyc), 32'(a_step), 32'(a_stepv(rel)));
    endtask

    task automatic runB(input string sc);
        int exp;
        applyStimulus(3'b010, 3'b000);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            exp = (cyc < 4) ? 'h055 : (cyc < 7) ? 'h17F : 'h3FF;
            checkOutput($sformatf("%s start c%0d", sc, cyc), 32'(b_out), 32'(exp));
            checkOutput($sformatf("%s busy c%0d", sc, cyc), 32'(b_busy), 32'(cyc <= 7));
            checkOutput($sformatf("%s done c%0d", sc, cyc), 32'(b_done), 32'(cyc == 7));
            applyStimulus(3'b000, 3'b000);
        end
        applyStimulus(3'b000, 3'b010);
        checkOutput({sc, " start after clear"}, 32'(b_out), 32'h0);
        checkOutput({sc, " busy after clear"}, 32'(b_busy), 32'h0);
    endtask

    initial begin
        logic [4:0] c_pulse [4];
        int         rel;
        logic       st;

        checks = 0;
        errors = 0;
        c_pulse[0] = 5'h18; c_pulse[1] = 5'h06; c_pulse[2] = 5'h01; c_pulse[3] = 5'h00;
        reset = 1'b1;
        a_start = 0; b_start = 0; c_start = 0;
        a_clear = 0; b_clear = 0; c_clear = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst a start", 32'(a_out), 32'h0);
        checkOutput("rst b start", 32'(b_out), 32'h0);
        checkOutput("rst busy", 32'({a_busy, b_busy, c_busy}), 32'h0);
        checkOutput("rst done", 32'({a_done, b_done, c_done}), 32'h0);
        checkOutput("rst step", 32'({a_step, b_step, c_step}), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] scenario 1: linear pulse");
        applyStimulus(3'b001, 3'b000);
        for (int cyc = 1; cyc <= 31; cyc++) begin
            checkA("s1", cyc, cyc);
            applyStimulus(3'b000, 3'b000);
        end

        $display("[TB] scenario 2: interleave level");
        runB("s2");

        $display("[TB] scenario 3: reverse pulse gap 1");
        applyStimulus(3'b100, 3'b000);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            checkOutput($sformatf("s3 start c%0d", cyc), 32'(c_out), 32'(c_pulse[cyc-1]));
            checkOutput($sformatf("s3 done c%0d", cyc), 32'(c_done), 32'(cyc == 3));
            checkOutput($sformatf("s3 busy c%0d", cyc), 32'(c_busy), 32'(cyc <= 3));
            checkOutput($sformatf("s3 step c%0d", cyc), 32'(c_step), 32'((cyc <= 3) ? cyc - 1 : 0));
            applyStimulus(3'b000, 3'b000);
        end

        $display("[TB] scenario 4: held start");
        applyStimulus(3'b001, 3'b000);
        for (int cyc = 1; cyc <= 72; cyc++) begin
            rel = (cyc >= 41) ? cyc - 40 : (cyc <= 29) ? cyc : 0;
            checkA("s4", cyc, rel);
            st = (cyc < 9) || (cyc >= 10 && cyc < 36) || (cyc >= 40);
            applyStimulus({2'b00, st}, 3'b000);
        end
        applyStimulus(3'b000, 3'b000);

        $display("[TB] scenario 5: clear mid-sequence");
        applyStimulus(3'b001, 3'b000);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            rel = (cyc <= 9) ? cyc : (cyc >= 13) ? cyc - 12 : 0;
            checkA("s5", cyc, rel);
            applyStimulus({2'b00, cyc == 12}, {2'b00, cyc == 9});
        end
        applyStimulus(3'b000, 3'b001);
        applyStimulus(3'b000, 3'b000);
        applyStimulus(3'b001, 3'b001);
        checkOutput("s5 clear+start busy", 32'(a_busy), 32'h0);
        applyStimulus(3'b001, 3'b000);
        checkOutput("s5 held after clear busy", 32'(a_busy), 32'h0);
        checkOutput("s5 held after clear start", 32'(a_out), 32'h0);
        applyStimulus(3'b000, 3'b000);

        $display("[TB] scenario 6: async reset mid-sequence");
        applyStimulus(3'b010, 3'b000);
        for (int cyc = 1; cyc < 5; cyc++) applyStimulus(3'b000, 3'b000);
        checkOutput("s6 pre-reset start", 32'(b_out), 32'h17F);
        checkOutput("s6 pre-reset step", 32'(b_step), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("s6 async start", 32'(b_out), 32'h0);
        checkOutput("s6 async busy", 32'(b_busy), 32'h0);
        checkOutput("s6 async step", 32'(b_step), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s6 idle after reset", 32'({b_busy, b_done}), 32'h0);
        runB("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
